frame_capture: RTL and testbench
================================

FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 SHALL have parameter IMG_W, default 32, pixels per line.
REQ-002 SHALL have parameter IMG_H, default 32, lines per frame; frame depth N = IMG_W*IMG_H = 1024.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port cap_en, input, 1, one-cycle arm request.
REQ-006 SHALL have port pix_in, input, 8, processed (Sobel) pixel data.
REQ-007 SHALL have port pix_valid, input, 1, pix_in qualifier.
REQ-008 SHALL have port pix_sof, input, 1, first pixel of frame; meaningful only with pix_valid.
REQ-009 SHALL have port rd_en, input, 1, readback request.
REQ-010 SHALL have port rd_addr, input, 10, readback address.
REQ-011 SHALL have port rd_data, output, 8, readback data.
REQ-012 SHALL have port rd_valid, output, 1, rd_data qualifier.
REQ-013 SHALL have port busy, output, 1, high in ARMED or CAPTURE.
REQ-014 SHALL have port frame_done, output, 1, high while in DONE.
REQ-015 SHALL have port pix_count, output, 11, pixels written in current frame.
REQ-016 SHALL have port col, output, 5, and row, output, 5, position of next pixel to write.
REQ-017 SHALL have port err_sof, output, 1, sticky: SOF seen mid-frame.
REQ-018 SHALL have port overflow, output, 1, sticky: valid pixel arrived in DONE.

Function
REQ-019 SHALL implement states IDLE, ARMED, CAPTURE, DONE.
REQ-020 IDLE: cap_en -> ARMED; pixels ignored.
REQ-021 ARMED: pix_valid&pix_sof -> write pix_in to address 0, pix_count=1, col=1, row=0, -> CAPTURE; pix_valid without SOF ignored.
REQ-022 CAPTURE: each pix_valid writes pix_in at address pix_count, increments pix_count; col wraps IMG_W-1 -> 0 with row+1.
REQ-023 CAPTURE: write of pixel N-1 -> DONE next cycle; pix_count holds N, col=0, row=0.
REQ-024 CAPTURE: pix_valid&pix_sof -> pixel written at address 0, pix_count=1, col=1, row=0, err_sof set.
REQ-025 DONE: pix_valid sets overflow; memory unchanged; cap_en -> ARMED, pix_count/col/row cleared.
REQ-026 Readback: rd_en in DONE -> rd_data = mem[rd_addr], rd_valid=1 exactly one cycle later; back-to-back rd_en gives one result per cycle.
REQ-027 rd_en outside DONE ignored; rd_valid=0, rd_data holds last value.
REQ-028 cap_en in ARMED or CAPTURE ignored.
REQ-029 Write and read address never collide: writes only outside DONE, reads only in DONE.
REQ-030 pix_count SHALL never exceed N; no wrap of write address.

Reset
REQ-031 rst SHALL force IDLE; busy, frame_done, rd_valid, err_sof, overflow, pix_count, col, row, rd_data = 0.
REQ-032 rst mid-CAPTURE SHALL abort frame next edge; memory contents not cleared.
REQ-033 rst SHALL dominate cap_en, pix_valid, rd_en in the same cycle.

Structure
REQ-034 Shared package frame_pkg SHALL hold IMG_W, IMG_H, N, address width 10 and state encoding.
REQ-035 Storage SHALL be sub-module capture_ram: N x 8, one sync write port, one sync read port, 1-cycle read latency.
REQ-036 FSM, counters and flags SHALL live in frame_capture; target 120-400 RTL lines.

Verification
REQ-037 Full frame: cap_en, then 1024 valid pixels 0x00..0xFF repeating, first with SOF -> frame_done at cycle after pixel 1023, pix_count=1024, rd_addr 300 -> rd_data 0x2C after 1 cycle.
REQ-038 Gaps: pix_valid toggled 50% -> same memory contents as REQ-037, frame_done only after 1024th valid.
REQ-039 SOF mid-frame: SOF at pixel 100 (data 0xAA) -> err_sof=1, mem[0]=0xAA, pix_count=1.
REQ-040 Overflow: valid pixel in DONE -> overflow=1, mem unchanged, frame_done stays 1.
REQ-041 Reset mid-CAPTURE at pix_count=500 -> IDLE, all outputs 0; subsequent pixels ignored until cap_en.
REQ-042 Read outside DONE: rd_en in ARMED -> rd_valid stays 0.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared constants and state encoding for the frame capture block.
// Frame geometry defaults, storage addressing and the capture FSM states.
package frame_pkg;
   localparam int IMG_W  = 32;
   localparam int IMG_H  = 32;
   localparam int N      = IMG_W * IMG_H;
   localparam int ADDR_W = 10;
   localparam int CNT_W  = 11;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;
endpackage

// File: rtl/capture_ram.sv
// Frame store: DEPTH x DATA_W, one synchronous write port and one synchronous
// read port with a single cycle of read latency.
// Ports:
//   clk, rst          - clock; rst clears only the read data register
//   we, wr_addr, wr_data - write port
//   re, rd_addr       - read request; rd_data updates on the next edge and
//                       holds its value when re is low
module capture_ram
   import frame_pkg::*;
#(
   parameter int DEPTH = N
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              re,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // The array itself is never reset; contents survive a capture abort.
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst)     rd_data <= '0;
      else if (re) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/frame_capture.sv
// Single-frame pixel capture with readback.
// Arm with cap_en, capture one IMG_W x IMG_H frame starting at a SOF pixel,
// then read the frame back while in DONE.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   cap_en                       - arm request (honoured in IDLE and DONE)
//   pix_in, pix_valid, pix_sof   - pixel stream
//   rd_en, rd_addr               - readback request (honoured in DONE only)
//   rd_data, rd_valid            - readback result, one cycle after rd_en
//   busy, frame_done             - status (ARMED/CAPTURE, DONE)
//   pix_count, col, row          - pixels written, position of next pixel
//   err_sof, overflow            - sticky error flags
//
// state   | meaning
// IDLE    | waiting for cap_en, pixels ignored
// ARMED   | waiting for a SOF pixel to start the frame
// CAPTURE | writing pixels sequentially into the frame store
// DONE    | frame complete, readback allowed, further pixels flag overflow
module frame_capture
   import frame_pkg::*;
#(
   parameter int IMG_W = frame_pkg::IMG_W,
   parameter int IMG_H = frame_pkg::IMG_H
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap_en,
   input  logic [DATA_W-1:0] pix_in,
   input  logic              pix_valid,
   input  logic              pix_sof,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              frame_done,
   output logic [CNT_W-1:0]  pix_count,
   output logic [4:0]        col,
   output logic [4:0]        row,
   output logic              err_sof,
   output logic              overflow
);

   localparam int NPIX = IMG_W * IMG_H;

   state_t            state;
   logic              we;
   logic              re;
   logic [ADDR_W-1:0] wr_addr;
   logic              col_last;
   logic              pix_last;

   assign col_last = (col == 5'(IMG_W - 1));
   assign pix_last = (pix_count == CNT_W'(NPIX - 1));

   // Writes happen only in ARMED/CAPTURE and reads only in DONE, so the two
   // RAM ports never address the same word in the same cycle.
   always_comb begin
      we      = 1'b0;
      wr_addr = '0;
      if (!rst) begin
         case (state)
            ST_ARMED:   we = pix_valid & pix_sof;
            ST_CAPTURE: begin
               we      = pix_valid;
               wr_addr = pix_sof ? '0 : pix_count[ADDR_W-1:0];
            end
            default:    we = 1'b0;
         endcase
      end
   end

   assign re = !rst && (state == ST_DONE) && rd_en;

   capture_ram #(.DEPTH(NPIX)) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .wr_addr (wr_addr),
      .wr_data (pix_in),
      .re      (re),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         rd_valid   <= 1'b0;
         err_sof    <= 1'b0;
         overflow   <= 1'b0;
         pix_count  <= '0;
         col        <= '0;
         row        <= '0;
      end else begin
         rd_valid <= re;
         case (state)
            ST_IDLE: begin
               if (cap_en) begin
                  state <= ST_ARMED;
                  busy  <= 1'b1;
               end
            end
            ST_ARMED: begin
               if (pix_valid && pix_sof) begin
                  state     <= ST_CAPTURE;
                  pix_count <= CNT_W'(1);
                  col       <= 5'd1;
                  row       <= 5'd0;
               end
            end
            ST_CAPTURE: begin
               if (pix_valid) begin
                  if (pix_sof) begin
                     // A new SOF restarts the frame at address 0.
                     pix_count <= CNT_W'(1);
                     col       <= 5'd1;
                     row       <= 5'd0;
                     err_sof   <= 1'b1;
                  end else if (pix_last) begin
                     state      <= ST_DONE;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                     pix_count  <= CNT_W'(NPIX);
                     col        <= 5'd0;
                     row        <= 5'd0;
                  end else begin
                     pix_count <= pix_count + 1'b1;
                     if (col_last) begin
                        col <= 5'd0;
                        row <= row + 1'b1;
                     end else begin
                        col <= col + 1'b1;
                     end
                  end
               end
            end
            ST_DONE: begin
               if (pix_valid) overflow <= 1'b1;
               if (cap_en) begin
                  state      <= ST_ARMED;
                  busy       <= 1'b1;
                  frame_done <= 1'b0;
                  pix_count  <= '0;
                  col        <= '0;
                  row        <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_capture.sv
// Bench for frame_capture: randomized pixel streams and readbacks, checked
// every cycle against a transaction-level reference model.
module tb_frame_capture;
   import frame_pkg::*;

   localparam int NP = IMG_W * IMG_H;

   logic        clk = 1'b0;
   logic        rst, cap_en, pix_valid, pix_sof, rd_en;
   logic [7:0]  pix_in;
   logic [9:0]  rd_addr;
   logic [7:0]  rd_data;
   logic        rd_valid, busy, frame_done, err_sof, overflow;
   logic [10:0] pix_count;
   logic [4:0]  col, row;

   frame_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk        (clk),
      .rst        (rst),
      .cap_en     (cap_en),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_sof    (pix_sof),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .busy       (busy),
      .frame_done (frame_done),
      .pix_count  (pix_count),
      .col        (col),
      .row        (row),
      .err_sof    (err_sof),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   // Reference model: mode 0 idle, 1 armed, 2 capturing, 3 frame complete.
   int         m_mode = 0;
   int         m_cnt  = 0;
   bit         m_err  = 0;
   bit         m_ovf  = 0;
   bit         m_rdv  = 0;
   logic [7:0] m_rdd  = 8'h00;
   logic [7:0] m_mem [NP];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit cap, input bit v, input bit sof,
                             input logic [7:0] d, input bit re, input int ra);
      if (r) begin
         m_mode = 0; m_cnt = 0; m_err = 0; m_ovf = 0; m_rdv = 0; m_rdd = 8'h00;
      end else begin
         m_rdv = (m_mode == 3) && re;
         if (m_rdv) m_rdd = m_mem[ra];
         case (m_mode)
            0: if (cap) m_mode = 1;
            1: if (v && sof) begin m_mem[0] = d; m_cnt = 1; m_mode = 2; end
            2: if (v) begin
                  if (sof) begin m_mem[0] = d; m_cnt = 1; m_err = 1; end
                  else begin
                     m_mem[m_cnt] = d;
                     m_cnt++;
                     if (m_cnt == NP) m_mode = 3;
                  end
               end
            default: begin
               if (v) m_ovf = 1;
               if (cap) begin m_mode = 1; m_cnt = 0; end
            end
         endcase
      end
   endtask

   task automatic cyc(input bit r, input bit cap, input bit v, input bit sof,
                      input logic [7:0] d, input bit re, input logic [9:0] ra);
      rst = r; cap_en = cap; pix_valid = v; pix_sof = sof; pix_in = d;
      rd_en = re; rd_addr = ra;
      @(posedge clk);
      model_step(r, cap, v, sof, d, re, int'(ra));
      #1;
      chk("busy",       busy,       (m_mode == 1 || m_mode == 2));
      chk("frame_done", frame_done, (m_mode == 3));
      chk("pix_count",  pix_count,  m_cnt);
      chk("col",        col,        m_cnt % IMG_W);
      chk("row",        row,        (m_cnt / IMG_W) % IMG_H);
      chk("err_sof",    err_sof,    m_err);
      chk("overflow",   overflow,   m_ovf);
      chk("rd_valid",   rd_valid,   m_rdv);
      chk("rd_data",    rd_data,    m_rdd);
   endtask

   task automatic idle_cyc();
      cyc(0, 0, 0, 0, 8'($urandom), 0, 10'($urandom));
   endtask

   // Sends nvalid valid pixels; data is index-pattern or random. Idle cycles
   // carry junk data/SOF; with noise, cap_en and rd_en are toggled randomly
   // (both must be ignored while capturing).
   task automatic feed(input int nvalid, input int gap_pct, input bit rnd_data,
                       input bit sof_first, input int base, input bit noise);
      int sent = 0;
      while (sent < nvalid) begin
         bit nc = noise && ($urandom_range(0, 9) == 0);
         bit nr = noise && ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 99) < gap_pct) begin
            cyc(0, nc, 0, 1'($urandom), 8'($urandom), nr, 10'($urandom));
         end else begin
            logic [7:0] d = rnd_data ? 8'($urandom) : 8'((base + sent) & 8'hFF);
            cyc(0, nc, 1, (sent == 0) && sof_first, d, nr, 10'($urandom));
            sent++;
         end
      end
   endtask

   task automatic rd_burst(input int n, input bit seq);
      for (int i = 0; i < n; i++)
         cyc(0, 0, 0, 0, 8'h00, 1, seq ? 10'(i) : 10'($urandom));
      idle_cyc();
   endtask

   initial begin
      for (int i = 0; i < NP; i++) m_mem[i] = 8'h00;

      // Reset state
      cyc(1, 0, 0, 0, 8'h00, 0, 10'd0);
      cyc(1, 1, 1, 1, 8'h55, 1, 10'd3);
      chk("rst_busy", busy, 0);
      chk("rst_rd_data", rd_data, 0);
      repeat (3) idle_cyc();
      // Pixels ignored in IDLE
      cyc(0, 0, 1, 1, 8'h12, 0, 10'd0);

      // Full frame, contiguous, pattern data
      cyc(0, 1, 0, 0, 8'h00, 0, 10'd0);
      // Read request in ARMED must be ignored; non-SOF pixel ignored too
      cyc(0, 0, 1, 0, 8'h77, 1, 10'd5);
      chk("armed_rd_valid", rd_valid, 0);
      feed(NP, 0, 0, 1, 0, 0);
      chk("full_done", frame_done, 1);
      chk("full_count", pix_count, 11'd1024);
      cyc(0, 0, 0, 0, 8'h00, 1, 10'd300);
      chk("rd300_data", rd_data, 8'h2C);
      chk("rd300_valid", rd_valid, 1);
      rd_burst(64, 0);

      // Overflow: valid pixel in DONE leaves memory alone
      cyc(0, 0, 1, 0, 8'hEE, 0, 10'd0);
      chk("ovf_flag", overflow, 1);
      chk("ovf_done", frame_done, 1);
      cyc(0, 0, 0, 0, 8'h00, 1, 10'd1023);
      chk("ovf_mem", rd_data, 8'hFF);

      // Same pattern with ~50% gaps and noise on cap_en/rd_en
      cyc(0, 1, 0, 0, 8'h00, 0, 10'd0);
      feed(NP - 1, 50, 0, 1, 0, 1);
      chk("gap_not_done", frame_done, 0);
      feed(1, 50, 0, 0, NP - 1, 1);
      chk("gap_done", frame_done, 1);
      rd_burst(NP, 1);

      // SOF mid-frame at pixel 100, then random data to completion
      cyc(0, 1, 0, 0, 8'h00, 0, 10'd0);
      feed(100, 30, 1, 1, 0, 1);
      cyc(0, 0, 1, 1, 8'hAA, 0, 10'd0);
      chk("sof_err", err_sof, 1);
      chk("sof_count", pix_count, 1);
      feed(NP - 1, 20, 1, 0, 0, 1);
      cyc(0, 0, 0, 0, 8'h00, 1, 10'd0);
      chk("sof_mem0", rd_data, 8'hAA);
      rd_burst(200, 0);

      // Reset mid-capture at 500 pixels, with every other input asserted
      cyc(0, 1, 0, 0, 8'h00, 0, 10'd0);
      feed(500, 25, 1, 1, 0, 0);
      chk("pre_rst_count", pix_count, 500);
      cyc(1, 1, 1, 1, 8'h99, 1, 10'd7);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_count", pix_count, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1'(i == 0), 8'($urandom), 1, 10'($urandom));
      cyc(0, 1, 0, 0, 8'h00, 0, 10'd0);
      feed(NP, 10, 1, 1, 0, 1);
      rd_burst(300, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
